// File: rtl/echo_ranger_if.sv
// Result channel from the echo ranger to display/threshold logic.
// Valid/ready handshake carrying the measured range and its qualifiers.
interface echo_ranger_if #(
    parameter int DIST_W = 9
);
    logic              dist_valid;
    logic              dist_ready;
    logic [DIST_W-1:0] dist_cm;
    logic              no_echo;
    logic              over_range;
    logic              near;

    modport master (
        output dist_valid,
        output dist_cm,
        output no_echo,
        output over_range,
        output near,
        input  dist_ready
    );

    modport slave (
        input  dist_valid,
        input  dist_cm,
        input  no_echo,
        input  over_range,
        input  near,
        output dist_ready
    );
endinterface

// File: rtl/echo_ranger.sv
// HC-SR04 echo pulse timer: measures echo high time and converts it to whole cm
// by prescaled counting, presenting one result per ping on a valid/ready channel.
module echo_ranger #(
    parameter int CYC_PER_CM  = 2900,
    parameter int DIST_W      = 9,
    parameter int MAX_CM      = 400,
    parameter int ARM_TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              echo,
    input  logic [DIST_W-1:0] near_cm,
    output logic              busy,
    echo_ranger_if.master     res
);

    localparam int CYC_W = $clog2(CYC_PER_CM);
    localparam int ARM_W = $clog2(ARM_TIMEOUT + 1);

    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(CYC_PER_CM - 1);
    localparam logic [CYC_W-1:0]  CYC_ONE  = CYC_W'(1);
    localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);
    localparam logic [DIST_W-1:0] CM_LAST  = DIST_W'(MAX_CM - 1);
    localparam logic [DIST_W-1:0] CM_MAX   = DIST_W'(MAX_CM);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic echo_m_q, echo_s_q, echo_d_q;

    logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
    logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic [DIST_W-1:0] cm_cnt_q,  cm_cnt_d;

    logic              dist_valid_q, dist_valid_d;
    logic [DIST_W-1:0] dist_cm_q,    dist_cm_d;
    logic              no_echo_q,    no_echo_d;
    logic              over_range_q, over_range_d;
    logic              near_q,       near_d;

    logic rise, fall, cm_tick, cm_hit_max, arm_done, accept;

    assign rise       = echo_s_q & ~echo_d_q;
    assign fall       = ~echo_s_q & echo_d_q;
    assign cm_tick    = echo_s_q & (cyc_cnt_q == CYC_LAST);
    assign cm_hit_max = cm_tick & (cm_cnt_q == CM_LAST);
    assign arm_done   = (arm_cnt_q == ARM_LAST);
    assign accept     = dist_valid_q & res.dist_ready;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            echo_m_q     <= 1'b0;
            echo_s_q     <= 1'b0;
            echo_d_q     <= 1'b0;
            arm_cnt_q    <= '0;
            cyc_cnt_q    <= '0;
            cm_cnt_q     <= '0;
            dist_valid_q <= 1'b0;
            dist_cm_q    <= '0;
            no_echo_q    <= 1'b0;
            over_range_q <= 1'b0;
            near_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            echo_m_q     <= echo;
            echo_s_q     <= echo_m_q;
            echo_d_q     <= echo_s_q;
            arm_cnt_q    <= arm_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            cm_cnt_q     <= cm_cnt_d;
            dist_valid_q <= dist_valid_d;
            dist_cm_q    <= dist_cm_d;
            no_echo_q    <= no_echo_d;
            over_range_q <= over_range_d;
            near_q       <= near_d;
        end
    end

    // Next state; a fall always wins over the MAX_CM wrap in MEASURE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ARMED;
            ARMED:   if (rise) state_d = MEASURE;
                     else if (arm_done) state_d = HOLD;
            MEASURE: if (fall || cm_hit_max) state_d = HOLD;
            HOLD:    if (accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters and result latching
    always_comb begin
        logic              load;
        logic [DIST_W-1:0] ld_dist;
        logic              ld_no_echo;
        logic              ld_over;

        arm_cnt_d    = arm_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        cm_cnt_d     = cm_cnt_q;
        dist_valid_d = dist_valid_q;
        dist_cm_d    = dist_cm_q;
        no_echo_d    = no_echo_q;
        over_range_d = over_range_q;
        near_d       = near_q;
        load         = 1'b0;
        ld_dist      = '0;
        ld_no_echo   = 1'b0;
        ld_over      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    arm_cnt_d = '0;
                    cyc_cnt_d = '0;
                    cm_cnt_d  = '0;
                end
            end
            ARMED: begin
                // The rise cycle already has echo_s high, so it is the first counted cycle
                if (rise) begin
                    cyc_cnt_d = CYC_ONE;
                end else if (arm_done) begin
                    load       = 1'b1;
                    ld_no_echo = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    load    = 1'b1;
                    ld_dist = cm_cnt_q;
                end else if (cm_tick) begin
                    cyc_cnt_d = '0;
                    cm_cnt_d  = cm_cnt_q + 1'b1;
                    if (cm_hit_max) begin
                        load    = 1'b1;
                        ld_dist = CM_MAX;
                        ld_over = 1'b1;
                    end
                end else if (echo_s_q) begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (accept) dist_valid_d = 1'b0;
            end
            default: ;
        endcase

        if (load) begin
            dist_valid_d = 1'b1;
            dist_cm_d    = ld_dist;
            no_echo_d    = ld_no_echo;
            over_range_d = ld_over;
            near_d       = ~ld_no_echo & ~ld_over & (ld_dist < near_cm);
        end
    end

    // Outputs
    always_comb begin
        busy           = (state_q != IDLE);
        res.dist_valid = dist_valid_q;
        res.dist_cm    = dist_cm_q;
        res.no_echo    = no_echo_q;
        res.over_range = over_range_q;
        res.near       = near_q;
    end

endmodule

// File: tb/tb_echo_ranger.sv
// Directed bench for echo_ranger with a scoreboard queue drained by a result monitor.
module tb_echo_ranger;

    localparam int DIST_W = 9;

    typedef struct packed {
        logic [DIST_W-1:0] d;
        logic              ne;
        logic              ov;
        logic              nr;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              echo;
    logic [DIST_W-1:0] near_cm;
    logic              busy;

    echo_ranger_if #(.DIST_W(DIST_W)) bus ();

    echo_ranger #(
        .CYC_PER_CM (10),
        .DIST_W     (DIST_W),
        .MAX_CM     (20),
        .ARM_TIMEOUT(100)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .echo   (echo),
        .near_cm(near_cm),
        .busy   (busy),
        .res    (bus.master)
    );

    always #5 clk = ~clk;

    res_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic check(input string name, input int got, input int exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic expect_res(input int d, input bit ne, input bit ov, input bit nr);
        res_t r;
        r.d  = DIST_W'(d);
        r.ne = ne;
        r.ov = ov;
        r.nr = nr;
        exp_q.push_back(r);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!bus.dist_valid && n < budget) begin
            tick(1);
            n++;
        end
        check(name, int'(bus.dist_valid), 1);
    endtask

    task automatic echo_pulse(input int high_cycles);
        echo = 1'b1;
        tick(high_cycles);
        echo = 1'b0;
    endtask

    // Monitor: every accepted result is compared against the head of the queue
    always @(negedge clk) begin
        if (rst_n && bus.dist_valid && bus.dist_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("dist_cm", int'(bus.dist_cm), int'(e.d));
                check("flags{no_echo,over,near}",
                      int'({bus.no_echo, bus.over_range, bus.near}),
                      int'({e.ne, e.ov, e.nr}));
            end
        end
    end

    initial begin
        int bad;
        rst_n          = 1'b0;
        start          = 1'b0;
        echo           = 1'b0;
        near_cm        = '0;
        bus.dist_ready = 1'b1;
        tick(3);
        check("rst_outputs", int'({busy, bus.dist_valid, bus.no_echo, bus.over_range, bus.near}), 0);
        check("rst_dist_cm", int'(bus.dist_cm), 0);
        rst_n = 1'b1;
        tick(2);

        // Over-range: result must arrive while echo is still high
        near_cm = 9'd13;
        expect_res(20, 0, 1, 0);
        pulse_start();
        tick(2);
        echo = 1'b1;
        tick(201);
        check("ovr_not_yet", int'(bus.dist_valid), 0);
        tick(1);
        check("ovr_valid_echo_high", int'(bus.dist_valid), 1);
        tick(300);
        echo = 1'b0;
        tick(10);
        check("ovr_idle", int'(busy), 0);

        // Nominal 125 cycles -> 12 cm, with 3-edge latency and 1-cycle valid
        expect_res(12, 0, 0, 1);
        pulse_start();
        tick(3);
        check("busy_armed", int'(busy), 1);
        echo_pulse(125);
        tick(2);
        check("lat_edge2", int'(bus.dist_valid), 0);
        tick(1);
        check("lat_edge3", int'(bus.dist_valid), 1);
        tick(1);
        check("valid_one_cycle", int'(bus.dist_valid), 0);
        tick(3);

        // Reset in the middle of a measurement
        pulse_start();
        tick(3);
        echo = 1'b1;
        tick(30);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", int'({busy, bus.dist_valid, bus.no_echo, bus.over_range, bus.near}), 0);
        check("midrst_dist_cm", int'(bus.dist_cm), 0);
        tick(2);
        rst_n = 1'b1;
        echo  = 1'b0;
        tick(5);
        check("postrst_idle", int'(busy), 0);

        // Near boundary: dist == near_cm is not near
        near_cm = 9'd12;
        expect_res(12, 0, 0, 0);
        pulse_start();
        tick(3);
        echo_pulse(125);
        wait_valid("near_eq_valid", 10);
        tick(3);

        // No echo: timeout after exactly 100 cycles in ARMED
        near_cm = 9'd13;
        expect_res(0, 1, 0, 0);
        pulse_start();
        tick(99);
        check("noecho_not_yet", int'(bus.dist_valid), 0);
        tick(1);
        check("noecho_valid", int'(bus.dist_valid), 1);
        tick(3);

        // Just under range: 199 cycles -> 19 cm, not over
        near_cm = 9'd5;
        expect_res(19, 0, 0, 0);
        pulse_start();
        tick(3);
        echo_pulse(199);
        wait_valid("edge199_valid", 10);
        tick(3);

        // Backpressure with two dropped starts
        bus.dist_ready = 1'b0;
        expect_res(6, 0, 0, 0);
        pulse_start();
        tick(3);
        echo_pulse(65);
        wait_valid("bp_valid", 10);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10 || i == 30) start = 1'b1;
            tick(1);
            start = 1'b0;
            if (!(bus.dist_valid && bus.dist_cm == 9'd6 && !bus.no_echo &&
                  !bus.over_range && !bus.near && busy)) bad++;
        end
        check("bp_stable_bad_cycles", bad, 0);
        bus.dist_ready = 1'b1;
        tick(1);
        check("bp_accept_valid", int'(bus.dist_valid), 0);
        check("bp_accept_busy", int'(busy), 0);
        tick(20);
        check("bp_starts_dropped", int'(busy), 0);

        // Stale echo: already high at start, only the second pulse counts
        near_cm = 9'd13;
        expect_res(4, 0, 0, 1);
        echo = 1'b1;
        tick(5);
        pulse_start();
        tick(3);
        echo = 1'b0;
        tick(5);
        echo_pulse(40);
        wait_valid("stale_valid", 10);
        tick(5);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
